cache_ram_ctrl: RTL
===================

Name: cache_ram_ctrl

Overview:
- Sequencing controller for a direct-mapped, write-through word cache in front of the slow RAM model.
- Accepts one requester transaction at a time over a ready/valid-style handshake, and serves read hits from its internal tag/data arrays.
- Read misses and all writes go to RAM over a req/ack handshake.
- Sits between the testbench/CPU-side driver and the ram_clever-style memory; replaces ad-hoc change-detection sequencing with an explicit FSM.

Parameters:
- INDEX_BITS, 4, number of cache index bits; 2**INDEX_BITS lines, one 32-bit word per line.
- CNT_W, 16, width of the hit/miss statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  requester transaction request.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  32  word address; index = addr[INDEX_BITS-1:0], tag = addr[31:INDEX_BITS].
- wdata  input  32  write data.
- flush  input  1  invalidate all cache lines.
- ready  output  1  controller can accept req this cycle.
- resp_valid  output  1  one-cycle pulse: transaction complete.
- rdata  output  32  read data, valid while resp_valid=1; 0 for writes.
- mem_req  output  1  RAM request, held until mem_ack.
- mem_we  output  1  RAM write enable.
- mem_addr  output  32  RAM address.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data, valid in the mem_ack cycle.
- mem_ack  input  1  RAM completion, single-cycle pulse.
- hit_count  output  CNT_W  read hits, saturating.
- miss_count  output  CNT_W  read misses, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all valid bits cleared.
  - ready=1 once rst_n=1 (0 while in reset).
  - resp_valid=0, rdata=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; counters 0.
  - Reset mid-transaction aborts it: mem_req drops immediately and no resp_valid is produced.
- ready = (state==IDLE) && !flush. A transaction is accepted on a rising edge with req && ready. addr, we and wdata are captured into internal registers; the requester may change them afterwards.
- States: IDLE, RD_MEM, WR_MEM, RESP.
- IDLE, flush=1: all valid bits cleared at the next edge. Flush beats a simultaneous req, which is not accepted. Flush outside IDLE is ignored (ready is already 0).
- IDLE, accepted read hit (valid[idx] && tag match):
  - -> RESP; rdata = cached word; hit_count += 1.
  - Latency: resp_valid in the cycle after acceptance.
- IDLE, accepted read miss:
  - -> RD_MEM; mem_req=1, mem_we=0, mem_addr=addr; miss_count += 1.
- RD_MEM:
  - Hold mem_* stable until mem_ack.
  - On mem_ack: line[idx] <= {tag, mem_rdata}, valid[idx]=1; rdata=mem_rdata; mem_req=0; -> RESP.
  - A miss fill evicts any previous tag at that index.
- IDLE, accepted write (write-through, no-allocate):
  - On a hit, the cached word is updated at acceptance. On a miss, the cache is unchanged.
  - -> WR_MEM with mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata.
- WR_MEM: on mem_ack, mem_req=0; rdata=0; -> RESP. Writes do not change the counters.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. ready=0 during RESP.
- Minimum latencies:
  - Read hit: 1 cycle.
  - Miss or write: 1 + RAM ack delay + 1.
  - A mem_ack arriving in the first cycle mem_req is high is legal.
- mem_ack outside RD_MEM/WR_MEM is ignored. mem_rdata is ignored except in RD_MEM on mem_ack.
- Counters saturate at 2**CNT_W-1; no wrap.
- Only one transaction is outstanding at any time; req while ready=0 is ignored (not queued).

Test Plan:
- Reset then read addr 0x10 with RAM acking after 3 cycles with 0xDEADBEEF:
  - mem_req high for 3 cycles with mem_addr=0x10, mem_we=0.
  - resp_valid 1 cycle later with rdata=0xDEADBEEF; miss_count=1.
- Repeat read of 0x10:
  - No mem_req; resp_valid the cycle after acceptance with rdata=0xDEADBEEF; hit_count=1.
- Write 0x10 <= 0x12345678, then read 0x10:
  - Write drives mem_we=1, mem_wdata=0x12345678 until ack.
  - Read hits and returns 0x12345678 without mem_req.
- Conflict at INDEX_BITS=4:
  - Read 0x20 (miss, fill 0xAAAA0000), then read 0x10 (same index 0, different tag): the 0x10 read misses.
  - Re-read 0x20: misses again.
- Flush and req asserted together in IDLE:
  - ready=0 that cycle; req not accepted.
  - Next read of a previously cached address misses.
- Assert rst_n=0 during RD_MEM:
  - mem_req drops immediately; no resp_valid.
  - After release, ready=1 and a read of the old address misses.

Source files
------------

// File: rtl/cache_ram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ram_ctrl_if
//  Description : Bus bundle for cache_ram_ctrl. Carries the requester-side
//                ready/valid transaction signals and the RAM-side req/ack
//                signals.
//                slave  : controller view (cache_ram_ctrl)
//                master : driver view (CPU-side requester plus RAM model)
//  Ports (signals):
//    req, we, addr[31:0], wdata[31:0], flush   requester -> controller
//    ready, resp_valid, rdata[31:0]            controller -> requester
//    mem_req, mem_we, mem_addr, mem_wdata      controller -> RAM
//    mem_rdata[31:0], mem_ack                  RAM -> controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_ram_ctrl_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        flush;
   logic        ready;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  req, we, addr, wdata, flush, mem_rdata, mem_ack,
      output ready, resp_valid, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr, wdata, flush, mem_rdata, mem_ack,
      input  ready, resp_valid, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/cache_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_ram_ctrl
//  Description : Direct-mapped, write-through, no-allocate word cache
//                controller in front of a slow req/ack RAM. One transaction
//                in flight at a time. Read hits are served from the internal
//                tag/data arrays; read misses and all writes go to RAM.
//  Ports:
//    clk         system clock, rising edge
//    rst_n       asynchronous active-low reset
//    bus         cache_ram_ctrl_if.slave (requester + RAM handshakes)
//    hit_count   saturating read-hit counter
//    miss_count  saturating read-miss counter
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_ram_ctrl #(
   parameter int INDEX_BITS = 4,
   parameter int CNT_W      = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   cache_ram_ctrl_if.slave       bus,
   output logic [CNT_W-1:0]      hit_count,
   output logic [CNT_W-1:0]      miss_count
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 32 - INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_MEM = 2'd1,
      WR_MEM = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    mem_req_q, mem_req_d;
   logic                    mem_we_q, mem_we_d;
   logic [31:0]             mem_addr_q, mem_addr_d;
   logic [31:0]             mem_wdata_q, mem_wdata_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [CNT_W-1:0]        hit_count_q, hit_count_d;
   logic [CNT_W-1:0]        miss_count_q, miss_count_d;
   logic [LINES-1:0]        valid_q, valid_d;

   logic [TAG_W-1:0]        tag_q  [LINES];
   logic [31:0]             data_q [LINES];

   // Line write port, shared by write-hit updates and miss fills
   logic                    line_we;
   logic [INDEX_BITS-1:0]   line_idx;
   logic [TAG_W-1:0]        line_tag;
   logic [31:0]             line_data;

   logic [INDEX_BITS-1:0]   req_idx;
   logic [TAG_W-1:0]        req_tag;
   logic                    req_hit;
   logic                    ready;
   logic                    accept;

   assign req_idx = bus.addr[INDEX_BITS-1:0];
   assign req_tag = bus.addr[31:INDEX_BITS];
   assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   // rst_n is folded in so ready reads 0 for the whole reset period
   assign ready  = rst_n && (state_q == IDLE) && !bus.flush;
   assign accept = bus.req && ready;

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      rdata_d      = rdata_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      valid_d      = valid_q;
      line_we      = 1'b0;
      line_idx     = req_idx;
      line_tag     = req_tag;
      line_data    = bus.wdata;

      case (state_q)
         IDLE: begin
            if (bus.flush) begin
               valid_d = '0;
            end else if (accept) begin
               if (bus.we) begin
                  // Write-through, no-allocate: refresh only a line that hits
                  line_we     = req_hit;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = bus.addr;
                  mem_wdata_d = bus.wdata;
                  state_d     = WR_MEM;
               end else if (req_hit) begin
                  rdata_d = data_q[req_idx];
                  if (hit_count_q != '1) begin
                     hit_count_d = hit_count_q + 1'b1;
                  end
                  state_d = RESP;
               end else begin
                  if (miss_count_q != '1) begin
                     miss_count_d = miss_count_q + 1'b1;
                  end
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = bus.addr;
                  state_d    = RD_MEM;
               end
            end
         end
         RD_MEM: begin
            if (bus.mem_ack) begin
               // The captured RAM address supplies index/tag for the fill
               line_we           = 1'b1;
               line_idx          = mem_addr_q[INDEX_BITS-1:0];
               line_tag          = mem_addr_q[31:INDEX_BITS];
               line_data         = bus.mem_rdata;
               valid_d[line_idx] = 1'b1;
               rdata_d           = bus.mem_rdata;
               mem_req_d         = 1'b0;
               state_d           = RESP;
            end
         end
         WR_MEM: begin
            if (bus.mem_ack) begin
               rdata_d   = '0;
               mem_req_d = 1'b0;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rdata_q      <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rdata_q      <= rdata_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         valid_q      <= valid_d;
      end
   end

   // Tag/data storage needs no reset: every line is qualified by valid_q
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[line_idx]  <= line_tag;
         data_q[line_idx] <= line_data;
      end
   end

   assign bus.ready      = ready;
   assign bus.resp_valid = (state_q == RESP);
   assign bus.rdata      = rdata_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign hit_count      = hit_count_q;
   assign miss_count     = miss_count_q;

endmodule
`default_nettype wire
